// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Grant counters are built only when ALU_ARB_STATS_EN is defined.
package alu_arb_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_OP_W   = 3;

   localparam logic [DEF_OP_W-1:0] ALU_OP_PASS = 3'b000;
   localparam logic [DEF_OP_W-1:0] ALU_OP_ADD  = 3'b010;
   localparam logic [DEF_OP_W-1:0] ALU_OP_XOR  = 3'b011;
   localparam logic [DEF_OP_W-1:0] ALU_OP_OR   = 3'b100;
   localparam logic [DEF_OP_W-1:0] ALU_OP_AND  = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 16-bit ALU; undefined opcodes yield zero.
module alu
   import alu_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned OP_W   = DEF_OP_W
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   op_i,
   output logic [DATA_W-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_W'(ALU_OP_PASS): result_o = b_i;
         OP_W'(ALU_OP_ADD):  result_o = a_i + b_i;
         OP_W'(ALU_OP_XOR):  result_o = a_i ^ b_i;
         OP_W'(ALU_OP_OR):   result_o = a_i | b_i;
         OP_W'(ALU_OP_AND):  result_o = a_i & b_i;
         default:            result_o = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational except for the last-grant flop.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_q, last_d;

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (en_i) begin
         // On a tie the requester that did not win last time goes first.
         if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
         end else begin
            gnt_o = req_i;
         end
      end
      if (|gnt_o) begin
         last_d = gnt_o[1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with registered operands and results.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned OP_W   = DEF_OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_illegal
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1
`endif
);

   arb_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              id_q, id_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_illegal_q, rsp_illegal_d;

   logic [1:0]        gnt;
   logic              arb_en;
   logic [DATA_W-1:0] alu_result;
   logic              op_illegal;

   // Gating with reset keeps both readies low while reset is held.
   assign arb_en = (state_q == StIdle) && !reset;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en_i  (arb_en),
      .req_i ({req1_valid, req0_valid}),
      .gnt_o (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   alu #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_result)
   );

   always_comb begin
      op_illegal = 1'b1;
      case (op_q)
         OP_W'(ALU_OP_PASS), OP_W'(ALU_OP_ADD), OP_W'(ALU_OP_XOR),
         OP_W'(ALU_OP_OR), OP_W'(ALU_OP_AND): op_illegal = 1'b0;
         default:                             op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      id_d          = id_q;
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         StIdle: begin
            if (|gnt) begin
               a_d     = gnt[1] ? req1_a  : req0_a;
               b_d     = gnt[1] ? req1_b  : req0_b;
               op_d    = gnt[1] ? req1_op : req0_op;
               id_d    = gnt[1];
               state_d = StExec;
            end
         end
         StExec: begin
            rsp_result_d  = alu_result;
            rsp_illegal_d = op_illegal;
            rsp_id_d      = id_q;
            state_d       = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         id_q          <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_result_q  <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         id_q          <= id_d;
         rsp_id_q      <= rsp_id_d;
         rsp_result_q  <= rsp_result_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign rsp_valid   = (state_q == StResp);
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_illegal = rsp_illegal_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (gnt[0] && (cnt0_q != 16'hFFFF)) begin
         cnt0_d = cnt0_q + 16'd1;
      end
      if (gnt[1] && (cnt1_q != 16'hFFFF)) begin
         cnt1_d = cnt1_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   // Counters are absent in this build.
`endif

endmodule
